// File: rtl/counter_191_chain.sv
// Cascadable 74xx191-style up/down counter: STAGES 4-bit stages with a
// bidirectional carry/borrow enable chain and synchronous parallel load.

module counter_191_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       cep,
    input  logic       en,
    input  logic       down,
    output logic [3:0] q,
    output logic       tc
);
    logic at_term;

    // Terminal value flips with direction: F for carry, 0 for borrow.
    assign at_term = down ? (q == 4'h0) : (q == 4'hF);
    assign tc      = en & at_term;

    always_ff @(posedge clk) begin
        if (rst)
            q <= 4'h0;
        else if (load)
            q <= d;
        else if (cep && en)
            q <= down ? q - 4'd1 : q + 4'd1;
    end
endmodule

module counter_191_chain #(
    parameter int STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*STAGES-1:0]   d,
    input  logic                  cep,
    input  logic                  cet,
    input  logic                  down,
    output logic [4*STAGES-1:0]   q,
    output logic [STAGES-1:0]     nib_tc,
    output logic                  tc
);
    logic [STAGES:0] en;

    // A stage's terminal count is exactly the next stage's enable.
    assign en[0] = cet;
    assign tc    = nib_tc[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        counter_191_stage u_stage (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .d    (d[4*i +: 4]),
            .cep  (cep),
            .en   (en[i]),
            .down (down),
            .q    (q[4*i +: 4]),
            .tc   (nib_tc[i])
        );
        assign en[i+1] = nib_tc[i];
    end
endmodule

// File: tb/tb_counter_191_chain.sv
// Self-checking bench for counter_191_chain (STAGES=3) against an arithmetic
// reference model of a 12-bit loadable up/down counter.

module tb_counter_191_chain;
    localparam int STAGES = 3;
    localparam int W      = 4 * STAGES;
    localparam int MOD    = 1 << W;

    logic              clk = 1'b0;
    logic              rst, load, cep, cet, down;
    logic [W-1:0]      d;
    logic [W-1:0]      q;
    logic [STAGES-1:0] nib_tc;
    logic              tc;

    int checks = 0;
    int errors = 0;
    int mq     = 0;

    counter_191_chain #(.STAGES(STAGES)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .d      (d),
        .cep    (cep),
        .cet    (cet),
        .down   (down),
        .q      (q),
        .nib_tc (nib_tc),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    // Stage i reports terminal when cet is high and the low 4*(i+1) bits of
    // the whole count sit at the terminal value for the direction.
    function automatic logic [STAGES-1:0] exp_nib(int v, bit dn, bit ct);
        logic [STAGES-1:0] r;
        r = '0;
        for (int i = 0; i < STAGES; i++) begin
            int m = 1 << (4 * (i + 1));
            r[i] = ct && ((v % m) == (dn ? 0 : m - 1));
        end
        return r;
    endfunction

    function automatic bit exp_tc(int v, bit dn, bit ct);
        return ct && (v == (dn ? 0 : MOD - 1));
    endfunction

    // One clock edge; model follows rst > load > count > hold.
    task automatic tick();
        bit r = rst, l = load, p = cep, t = cet, dn = down;
        int dv = int'(d);
        @(posedge clk);
        if (r)           mq = 0;
        else if (l)      mq = dv;
        else if (p && t) mq = dn ? (mq + MOD - 1) % MOD : (mq + 1) % MOD;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; load = 0; d = '0; cep = 0; cet = 0; down = 0;
        tick();
        checks++;
        if (q !== '0) begin
            errors++; $display("FAIL reset_q got=%h want=000", q);
        end
        checks++;
        if (tc !== 1'b0 || nib_tc !== '0) begin
            errors++; $display("FAIL reset_tc got tc=%b nib=%b want 0/000", tc, nib_tc);
        end
    endtask

    task automatic test_count_up();
        int bad = 0;
        rst = 1; tick();
        rst = 0; cep = 1; cet = 1; down = 0;
        for (int n = 1; n <= MOD; n++) begin
            tick();
            checks++;
            if (q !== W'(n % MOD) || tc !== (n % MOD == MOD - 1)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL count_up n=%0d got q=%h tc=%b want q=%h tc=%b",
                             n, q, tc, W'(n % MOD), (n % MOD == MOD - 1));
            end
        end
    endtask

    task automatic test_borrow();
        load = 1; d = 12'h100; cep = 1; cet = 1; down = 0;
        tick();
        load = 0; down = 1;
        tick();
        checks++;
        if (q !== 12'h0FF) begin
            errors++; $display("FAIL borrow_q got=%h want=0ff", q);
        end
        down = 0; #1;
        checks++;
        if (nib_tc !== 3'b011 || tc !== 1'b0) begin
            errors++; $display("FAIL borrow_nib got nib=%b tc=%b want 011/0", nib_tc, tc);
        end
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] wq [3];
        logic         wt [3];
        wq[0] = 12'h001; wq[1] = 12'h000; wq[2] = 12'hFFF;
        wt[0] = 1'b0;    wt[1] = 1'b1;    wt[2] = 1'b0;
        load = 1; d = 12'h002; cep = 1; cet = 1; down = 1;
        tick();
        load = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (q !== wq[k] || tc !== wt[k]) begin
                errors++;
                $display("FAIL down_wrap k=%0d got q=%h tc=%b want q=%h tc=%b",
                         k, q, tc, wq[k], wt[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        load = 1; d = 12'hA5C; cep = 1; cet = 1; down = 0;
        tick();
        checks++;
        if (q !== 12'hA5C) begin
            errors++; $display("FAIL load_q got=%h want=a5c", q);
        end
        load = 0; cep = 0;
        repeat (5) tick();
        checks++;
        if (q !== 12'hA5C || tc !== 1'b0) begin
            errors++; $display("FAIL cep_hold got q=%h tc=%b want a5c/0", q, tc);
        end
    endtask

    task automatic test_cet_gate();
        load = 1; d = 12'hFFF; cep = 1; cet = 0; down = 0;
        tick();
        load = 0;
        tick();
        checks++;
        if (q !== 12'hFFF || tc !== 1'b0) begin
            errors++; $display("FAIL cet_hold got q=%h tc=%b want fff/0", q, tc);
        end
        cet = 1; #1;
        checks++;
        if (tc !== 1'b1 || nib_tc !== 3'b111) begin
            errors++; $display("FAIL cet_raise got tc=%b nib=%b want 1/111", tc, nib_tc);
        end
        tick();
        checks++;
        if (q !== 12'h000) begin
            errors++; $display("FAIL cet_wrap got=%h want=000", q);
        end
    endtask

    task automatic test_reset_priority();
        load = 1; d = 12'h3E0; cep = 1; cet = 1; down = 0;
        tick();
        load = 0;
        repeat (4) tick();
        rst = 1; load = 1; d = 12'h123;
        tick();
        rst = 0; load = 0; down = 1; cet = 1; cep = 0; #1;
        checks++;
        if (q !== 12'h000 || tc !== 1'b1) begin
            errors++; $display("FAIL rst_over_load got q=%h tc=%b want 000/1", q, tc);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        rst = 1; load = 0; tick();
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            d    = W'($urandom);
            cep  = ($urandom_range(0, 3) != 0);
            cet  = ($urandom_range(0, 4) != 0);
            down = ($urandom_range(0, 31) < 12) ? ~down : down;
            if ($urandom_range(0, 7) == 0) begin
                load = 1; d = $urandom_range(0, 1) ? 12'hFFE : 12'h001;
            end
            #1;
            checks++;
            if (tc !== exp_tc(mq, down, cet) || nib_tc !== exp_nib(mq, down, cet)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL rand_tc n=%0d q=%h got tc=%b nib=%b want tc=%b nib=%b",
                             n, q, tc, nib_tc, exp_tc(mq, down, cet), exp_nib(mq, down, cet));
            end
            tick();
            checks++;
            if (q !== W'(mq)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL rand_q n=%0d got=%h want=%h", n, q, W'(mq));
            end
        end
    endtask

    initial begin
        rst = 1; load = 0; d = '0; cep = 0; cet = 0; down = 0;
        #1;
        test_reset();
        test_count_up();
        test_borrow();
        test_down_wrap();
        test_load_priority();
        test_cet_gate();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
